count_seg_display: RTL and testbench

Downstream display stage for the special step counter. Takes the counter's 4-bit `count` (0–15) and splits it into two decimal digits. Drives two multiplexed 7-segment digits on the lab board: units and tens. All outputs are registered, and digits alternate at a parameterised refresh rate.

---
 rtl/seg_display_pkg.sv | 25 ++
 rtl/seg7_decoder.sv | 17 +
 rtl/count_seg_display.sv | 94 +++++++++
 tb/tb_count_seg_display.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and segment patterns for the 7-segment display blocks.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

    typedef enum logic {
        UNITS = 1'b0,
        TENS  = 1'b1
    } digit_sel_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-decimal inputs (10-15) produce a dark digit.
module seg7_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (val_i <= 4'd9) begin
            seg_o = SEG_LUT[val_i];
        end
    end

endmodule

// File: rtl/count_seg_display.sv
// Two-digit multiplexed 7-segment driver for a 0-15 counter value.
// Input register, refresh timer, units/tens select FSM and registered outputs.
module count_seg_display
    import seg_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp
);

    localparam int            CW       = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] LAST     = CW'(REFRESH_CYCLES - 1);
    localparam logic [6:0]    SEG_IDLE = ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic [1:0]    AN_IDLE  = ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [3:0]    count_q;
    logic [CW-1:0] refresh_q, refresh_d;
    digit_sel_t    sel_q, sel_d;
    logic          wrap;

    logic [3:0]    tens, units, digit;
    logic [6:0]    pat, seg_hi;
    logic [1:0]    an_hi;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    // Refresh timer and digit select advance together on the wrap cycle.
    assign wrap = (refresh_q == LAST);

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        sel_d     = sel_q;
        if (wrap) begin
            refresh_d = '0;
            sel_d     = (sel_q == UNITS) ? TENS : UNITS;
        end
    end

    always_comb begin
        tens  = 4'd0;
        units = count_q;
        if (count_q >= 4'd10) begin
            tens  = 4'd1;
            units = count_q - 4'd10;
        end
    end

    assign digit = (sel_q == TENS) ? tens : units;

    seg7_decoder u_dec (
        .val_i (digit),
        .seg_o (pat)
    );

    // Polarity is applied before the output flops so pins come straight off registers.
    always_comb begin
        seg_hi = pat;
        an_hi  = (sel_q == TENS) ? 2'b10 : 2'b01;
        if (sel_q == TENS && blank_lz && tens == 4'd0) begin
            seg_hi = SEG_OFF;
            an_hi  = 2'b00;
        end
        seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= 4'd0;
            refresh_q <= '0;
            sel_q     <= UNITS;
            seg_q     <= SEG_IDLE;
            an_q      <= AN_IDLE;
        end else begin
            count_q   <= count;
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = ACTIVE_LOW ? 1'b1 : 1'b0;

endmodule

// File: tb/tb_count_seg_display.sv
// Bench for count_seg_display: vector table, multi-cycle corner sequences and
// random stimulus against a slot/arithmetic reference model.
module tb_count_seg_display;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = 4'd7;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // output edges since reset release
    int prev_cq = 0;   // counter value the DUT sampled on the previous edge

    count_seg_display #(.REFRESH_CYCLES(R), .ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic       blank;
        logic [6:0] exp_u;
        logic [6:0] exp_t;
        logic [1:0] exp_an;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(string name, logic [9:0] act, logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {dp,an,seg}=%b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge, model prediction, then compare 1 time unit later.
    task automatic tick(string tag);
        logic [9:0] exp;
        int slot;
        @(posedge clk);
        if (!rst) begin
            exp = {1'b1, 2'b11, 7'h7f};
        end else begin
            k++;
            slot = ((k - 1) / R) % 2;
            if (slot == 0)
                exp = {1'b1, 2'b10, ~seg_of(prev_cq % 10)};
            else if (blank_lz && (prev_cq / 10) == 0)
                exp = {1'b1, 2'b11, 7'h7f};
            else
                exp = {1'b1, 2'b01, ~seg_of(prev_cq / 10)};
            prev_cq = int'(count);
        end
        #1;
        check(tag, {dp, an, seg}, exp);
    endtask

    task automatic run_vec(vec_t v);
        count    = v.cnt;
        blank_lz = v.blank;
        for (int i = 0; i < 2 * R + 2; i++) begin
            tick("vec_model");
            if (i >= 2) begin
                if (an == 2'b10) check("vec_units", {dp, an, seg}, {1'b1, 2'b10, v.exp_u});
                else             check("vec_tens",  {dp, an, seg}, {1'b1, v.exp_an, v.exp_t});
            end
        end
    endtask

    initial begin
        vecs[0] = '{cnt: 4'd5,  blank: 1'b0, exp_u: 7'b0010010, exp_t: 7'b1000000, exp_an: 2'b01};
        vecs[1] = '{cnt: 4'd13, blank: 1'b0, exp_u: 7'b0110000, exp_t: 7'b1111001, exp_an: 2'b01};
        vecs[2] = '{cnt: 4'd3,  blank: 1'b1, exp_u: 7'b0110000, exp_t: 7'b1111111, exp_an: 2'b11};
        vecs[3] = '{cnt: 4'd10, blank: 1'b1, exp_u: 7'b1000000, exp_t: 7'b1111001, exp_an: 2'b01};
        vecs[4] = '{cnt: 4'd0,  blank: 1'b1, exp_u: 7'b1000000, exp_t: 7'b1111111, exp_an: 2'b11};
        vecs[5] = '{cnt: 4'd15, blank: 1'b0, exp_u: 7'b0010010, exp_t: 7'b1111001, exp_an: 2'b01};
        vecs[6] = '{cnt: 4'd8,  blank: 1'b0, exp_u: 7'b0000000, exp_t: 7'b1000000, exp_an: 2'b01};

        // Reset: outputs dark while held, units enabled one edge after release.
        #1 rst = 1'b0;
        #1 check("reset_async", {dp, an, seg}, {1'b1, 2'b11, 7'h7f});
        tick("reset_hold");
        tick("reset_hold");
        #3 rst = 1'b1;
        k = 0; prev_cq = 0;
        tick("release");
        check("release_an", {8'd0, an}, {8'd0, 2'b10});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Count steps 9 -> 11 on the units->tens wrap edge.
        blank_lz = 1'b0;
        count    = 4'd9;
        tick("wrap_pre");
        tick("wrap_pre");
        for (int i = 0; i < 2 * R && ((k + 1) % (2 * R)) != R; i++) tick("wrap_align");
        count = 4'd11;
        tick("wrap_edge");
        check("wrap_edge_units9", {dp, an, seg}, {1'b1, 2'b10, 7'b0010000});
        tick("wrap_next");
        check("wrap_tens1", {dp, an, seg}, {1'b1, 2'b01, 7'b1111001});
        for (int i = 0; i < R - 1; i++) begin
            tick("wrap_tens_slot");
            check("wrap_tens_hold", {dp, an, seg}, {1'b1, 2'b01, 7'b1111001});
        end

        // Reset asserted during the tens slot.
        for (int i = 0; i < 2 * R && ((k - 1) / R) % 2 != 1; i++) tick("midrst_align");
        #2 rst = 1'b0;
        #1 check("midrst_async", {dp, an, seg}, {1'b1, 2'b11, 7'h7f});
        k = 0; prev_cq = 0;
        tick("midrst_hold");
        tick("midrst_hold");
        #3 rst = 1'b1;
        for (int i = 0; i < 2 * R; i++) begin
            tick("midrst_post");
            check("midrst_slot_an", {8'd0, an}, {8'd0, (i < R) ? 2'b10 : 2'b01});
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) count = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
